fib_engine_arbiter: RTL and testbench

- Shares one Fibonacci engine (in_valid/in_level -> out_valid/result pulse interface) among NUM_REQ independent requesters.
- Round-robin arbitration; one job in flight at a time.
- Range-checks levels before issue; enforces an engine timeout.
- Returns a tagged response (id, result, error) over a valid/ready channel.

---
 rtl/fib_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/fib_engine_arbiter.sv | 137 +++++++++++++
 tb/tb_fib_engine_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci engine arbiter.
package fib_pkg;

  localparam int FIB_W         = 8;
  localparam int MAX_LEVEL_DEF = 13;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Iterative Fibonacci with F(0)=0, F(1)=1; wraps modulo 2**FIB_W beyond F(13).
  function automatic logic [FIB_W-1:0] fib_ref(input logic [FIB_W-1:0] level);
    logic [FIB_W-1:0] a;
    logic [FIB_W-1:0] b;
    logic [FIB_W-1:0] t;
    a = '0;
    b = FIB_W'(1);
    for (int i = 0; i < (2**FIB_W) - 1; i++) begin
      if (i < int'(level)) begin
        t = a + b;
        a = b;
        b = t;
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Pick the first requester at ptr+1, ptr+2, ... (mod NUM_REQ).
  always_comb begin
    int              c;
    logic [ID_W-1:0] kk;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    kk    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c  = (int'(ptr) + i) % NUM_REQ;
      kk = ID_W'(c);
      if (!any && req[kk]) begin
        any       = 1'b1;
        grant[kk] = 1'b1;
        idx       = kk;
      end
    end
  end

endmodule

// File: rtl/fib_engine_arbiter.sv
// Shares one Fibonacci engine among NUM_REQ requesters, one job at a time,
// with level range checking, an engine timeout and a tagged response channel.
module fib_engine_arbiter
  import fib_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_LEVEL = MAX_LEVEL_DEF,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [FIB_W*NUM_REQ-1:0] req_level,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [FIB_W-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     eng_in_valid,
  output logic [FIB_W-1:0]         eng_in_level,
  input  logic                     eng_out_valid,
  input  logic [FIB_W-1:0]         eng_result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [FIB_W-1:0]   level_q, level_d;
  logic [FIB_W-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic [FIB_W-1:0]   gnt_level;
  logic               gnt_legal;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .grant(grant),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  // Level of the current winner (grant is one-hot) and its range check.
  always_comb begin
    gnt_level = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) gnt_level = req_level[FIB_W*k +: FIB_W];
    end
    gnt_legal = (gnt_level != '0) && (gnt_level <= FIB_W'(MAX_LEVEL));
  end

  // Next-state and latched-register update for the job sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    level_d  = level_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          id_d     = gnt_idx;
          level_d  = gnt_level;
          rr_ptr_d = gnt_idx;
          result_d = '0;
          err_d    = !gnt_legal;
          // Illegal levels go straight to a response; the engine is never started.
          state_d  = gnt_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done pulse on the last allowed cycle still counts as success.
        if (eng_out_valid) begin
          result_d = eng_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched registers; reset clears everything visible on the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      level_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      level_q  <= level_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE && !rst) ? grant : '0;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = id_q;
  assign rsp_result   = result_q;
  assign rsp_err      = err_q;
  assign eng_in_valid = (state_q == ISSUE);
  assign eng_in_level = (state_q == ISSUE) ? level_q : '0;

endmodule

// File: tb/tb_fib_engine_arbiter.sv
// Directed plus randomized bench for fib_engine_arbiter with a timeline reference model.
module tb_fib_engine_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MAXL    = 13;
  localparam int TMO     = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_level;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_result;
  logic                 rsp_err;
  logic                 eng_in_valid;
  logic [7:0]           eng_in_level;
  logic                 eng_out_valid;
  logic [7:0]           eng_result;

  int n_tests = 0;
  int n_fail  = 0;
  int last_g;

  fib_engine_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_W     (ID_W),
    .MAX_LEVEL(MAXL),
    .TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_level    (req_level),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_err      (rsp_err),
    .eng_in_valid (eng_in_valid),
    .eng_in_level (eng_in_level),
    .eng_out_valid(eng_out_valid),
    .eng_result   (eng_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] fib(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return 8'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req_ready"},  32'(req_ready), 0);
    chk({tag, ".rsp_valid"},  32'(rsp_valid), 0);
    chk({tag, ".rsp_id"},     32'(rsp_id), 0);
    chk({tag, ".rsp_result"}, 32'(rsp_result), 0);
    chk({tag, ".rsp_err"},    32'(rsp_err), 0);
    chk({tag, ".eng_in_vld"}, 32'(eng_in_valid), 0);
    chk({tag, ".eng_in_lvl"}, 32'(eng_in_level), 0);
  endtask

  // One complete job: model picks the winner, predicts the timeline from the
  // accept edge, plays the engine (delay dly, dly<1 = never) and stalls rsp_ready.
  task automatic run_round(input logic [NUM_REQ-1:0] vld, input int dly,
                           input int stall, input bit late8);
    int         g, c, lvl, rsp_k, seen;
    bit         legal, tmo, eng_now;
    logic [7:0] exp_res;
    g = -1;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (last_g + i) % NUM_REQ;
      if (g < 0 && vld[c]) g = c;
    end
    req_valid = vld;
    #1;
    chk("grant", 32'(req_ready), 32'(1 << g));
    lvl     = int'(req_level[8*g +: 8]);
    legal   = (lvl >= 1) && (lvl <= MAXL);
    tmo     = legal && !(dly >= 1 && dly <= TMO);
    rsp_k   = !legal ? 1 : (tmo ? 2 + TMO : 2 + dly);
    exp_res = (!legal || tmo) ? 8'd0 : fib(lvl);
    last_g  = g;
    seen    = 0;
    tick();
    for (int k = 1; k <= rsp_k + stall; k++) begin
      chk("eng_in_valid", 32'(eng_in_valid), 32'(legal && k == 1));
      chk("eng_in_level", 32'(eng_in_level), (legal && k == 1) ? 32'(lvl) : 0);
      chk("rsp_valid", 32'(rsp_valid), 32'(k >= rsp_k));
      if (k == 1) seen = int'(eng_in_level);
      if (k >= rsp_k) begin
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_result", 32'(rsp_result), 32'(exp_res));
        chk("rsp_err", 32'(rsp_err), 32'(!legal || tmo));
      end
      eng_now       = legal && dly >= 1 && k == 1 + dly;
      eng_out_valid = 1'b0;
      eng_result    = 8'($urandom);
      if (eng_now) begin
        eng_out_valid = 1'b1;
        eng_result    = fib(seen);
      end else if (k == 1 || k >= rsp_k) begin
        eng_out_valid = 1'($urandom);
        if (late8 && k >= rsp_k) begin
          eng_out_valid = 1'b1;
          eng_result    = 8'd8;
        end
      end
      rsp_ready = (k < rsp_k) ? 1'($urandom) : (k == rsp_k + stall);
      #1;
      chk("req_ready_busy", 32'(req_ready), 0);
      tick();
    end
    eng_out_valid = 1'b0;
    rsp_ready     = 1'b0;
    chk("rsp_valid_after", 32'(rsp_valid), 0);
    chk("eng_in_valid_after", 32'(eng_in_valid), 0);
  endtask

  initial begin
    int dly, mode;
    rst           = 1'b1;
    req_valid     = '0;
    req_level     = '0;
    rsp_ready     = 1'b0;
    eng_out_valid = 1'b0;
    eng_result    = '0;
    last_g        = NUM_REQ - 1;

    chk("fib_ref10", 32'(fib_pkg::fib_ref(8'd10)), 32'(fib(10)));
    chk("fib_ref13", 32'(fib_pkg::fib_ref(8'd13)), 32'd233);

    // Reset state, with every requester asking.
    tick();
    tick();
    req_valid = '1;
    #1;
    chk_all_zero("reset");
    req_valid = '0;
    rst       = 1'b0;

    // Fairness: all valid, levels 1,5,7,13 -> grants 0,1,2,3 twice.
    req_level = {8'd13, 8'd7, 8'd5, 8'd1};
    for (int r = 0; r < 2 * NUM_REQ; r++) begin
      run_round(4'b1111, $urandom_range(1, 15), 0, 1'b0);
      chk("rotation", 32'(last_g), 32'(r % NUM_REQ));
    end
    req_valid = '0;

    // Single request from req 0, level 10, engine latency 11.
    req_level = {8'd0, 8'd0, 8'd0, 8'd10};
    run_round(4'b0001, 11, 0, 1'b0);
    req_valid = '0;

    // Illegal levels from req 2.
    req_level[23:16] = 8'd0;
    run_round(4'b0100, 5, 0, 1'b0);
    req_valid        = '0;
    req_level[23:16] = 8'd14;
    run_round(4'b0100, 5, 0, 1'b0);
    req_valid        = '0;
    req_level[23:16] = 8'd255;
    run_round(4'b0100, 5, 0, 1'b0);
    req_valid        = '0;

    // Timeout with a late result of 8, boundary latencies, then a normal job.
    req_level[15:8] = 8'd6;
    run_round(4'b0010, -1, 0, 1'b1);
    run_round(4'b0010, TMO, 0, 1'b0);
    run_round(4'b0010, TMO + 1, 1, 1'b0);
    req_level[15:8] = 8'd7;
    run_round(4'b0010, 3, 0, 1'b0);
    req_valid = '0;

    // Response stall of 5 cycles while everybody waits (result 21).
    req_level = {8'd8, 8'd8, 8'd8, 8'd8};
    run_round(4'b1111, 4, 5, 1'b1);
    req_valid = '0;

    // Reset while waiting on the engine, then a stale done pulse.
    req_level = {8'd0, 8'd0, 8'd0, 8'd9};
    req_valid = 4'b0001;
    #1;
    chk("rst_job.grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    chk("rst_job.issue", 32'(eng_in_level), 32'd9);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_wait");
    eng_out_valid = 1'b1;
    eng_result    = 8'd34;
    tick();
    eng_out_valid = 1'b0;
    chk("stale.rsp_valid", 32'(rsp_valid), 0);
    chk("stale.rsp_result", 32'(rsp_result), 0);
    last_g = NUM_REQ - 1;
    run_round(4'b0001, 5, 0, 1'b0);
    req_valid = '0;

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NUM_REQ; i++) req_level[8*i +: 8] = 8'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 7));
      if (mode == 0)      dly = int'($urandom_range(TMO - 4, TMO + 6));
      else if (mode == 1) dly = -1;
      else                dly = int'($urandom_range(1, 12));
      run_round(4'($urandom_range(1, 15)), dly, int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        req_valid = '0;
        tick();
        chk("idle.rsp_valid", 32'(rsp_valid), 0);
      end
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
